// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-wide memory port shared between instruction fetch and LSU
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_lsu, r_inflight, r_wr;
    logic [2:0]  r_n, r_issue, r_recv;
    logic [31:0] r_addr, r_wdata, r_buf, r_mem_addr, r_if_data, r_lsu_rdata;
    logic [7:0]  r_dout;
    logic        w_grant_if, w_flush;
    logic [2:0]  w_lsu_n, w_recv_next;
    logic [31:0] w_buf;

    assign w_grant_if  = if_req & ~if_flush;
    assign w_flush     = if_flush & rdy_in & ~r_lsu & (r_state == READ || r_state == DONE);
    assign w_lsu_n     = lsu_size[1] ? 3'd4 : (lsu_size[0] ? 3'd2 : 3'd1);
    assign w_recv_next = r_recv + {2'b00, r_inflight};
    assign if_done     = (r_state == DONE) & ~r_lsu & ~w_flush;
    assign lsu_done    = (r_state == DONE) & r_lsu;
    assign if_data     = r_if_data;
    assign lsu_rdata   = r_lsu_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_dout    = r_dout;
    assign mem_wr      = r_wr & rdy_in;
    assign busy        = r_state != IDLE;

    always_comb begin
        w_buf = r_buf;
        if (r_inflight) w_buf[{r_recv[1:0], 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        w_next = r_state;
        if (rdy_in)
            case (r_state)
                IDLE:    w_next = lsu_req ? (lsu_we ? WRITE : READ) : (w_grant_if ? READ : IDLE);
                READ:    w_next = w_flush ? IDLE : ((w_recv_next == r_n) ? DONE : READ);
                WRITE:   w_next = (r_issue == r_n) ? DONE : WRITE;
                default: w_next = IDLE;
            endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_lsu       <= 1'b0;
            r_inflight  <= 1'b0;
            r_wr        <= 1'b0;
            r_n         <= 3'd0;
            r_issue     <= 3'd0;
            r_recv      <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_dout      <= 8'd0;
            r_if_data   <= 32'd0;
            r_lsu_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (!rdy_in) begin
                // a stalled read rewinds issue to the first byte not yet captured
                if (r_state == READ) begin
                    r_mem_addr <= r_addr + {29'd0, r_recv};
                    r_issue    <= r_recv + 3'd1;
                    r_inflight <= 1'b0;
                end
            end else
                case (r_state)
                    IDLE: if (lsu_req || w_grant_if) begin
                        r_lsu      <= lsu_req;
                        r_addr     <= lsu_req ? lsu_addr : if_addr;
                        r_mem_addr <= lsu_req ? lsu_addr : if_addr;
                        r_n        <= lsu_req ? w_lsu_n : 3'd4;
                        r_wdata    <= lsu_wdata;
                        r_dout     <= lsu_wdata[7:0];
                        r_wr       <= lsu_req & lsu_we;
                        r_issue    <= 3'd1;
                        r_recv     <= 3'd0;
                        r_inflight <= 1'b0;
                        r_buf      <= 32'd0;
                    end
                    READ: begin
                        r_inflight <= w_recv_next < r_issue;
                        r_recv     <= w_recv_next;
                        r_buf      <= w_buf;
                        if (r_issue < r_n) begin
                            r_mem_addr <= r_addr + {29'd0, r_issue};
                            r_issue    <= r_issue + 3'd1;
                        end
                        if (w_next == DONE) begin
                            if (r_lsu) r_lsu_rdata <= w_buf;
                            else r_if_data <= w_buf;
                        end
                    end
                    WRITE: begin
                        if (r_issue < r_n) begin
                            r_mem_addr <= r_addr + {29'd0, r_issue};
                            r_dout     <= r_wdata[{r_issue[1:0], 3'b000} +: 8];
                            r_issue    <= r_issue + 3'd1;
                        end else r_wr <= 1'b0;
                    end
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a byte-memory model
module tb_mem_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, if_req, if_flush, lsu_req, lsu_we;
    logic [31:0] if_addr, lsu_addr, lsu_wdata;
    logic [1:0]  lsu_size;
    logic [7:0]  mem_din;
    logic        if_done, lsu_done, mem_wr, busy;
    logic [31:0] if_data, lsu_rdata, mem_addr;
    logic [7:0]  mem_dout;

    int errors = 0, checks = 0;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] env_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        return w;
    endfunction
    function automatic int nbytes(input logic [1:0] s);
        return s[1] ? 4 : (s[0] ? 2 : 1);
    endfunction

    // byte memory: read data appears the cycle after the address, writes land on the edge
    always @(posedge clk_in) begin
        if (mem_wr) env_mem[mem_addr] = mem_dout;
        mem_din <= env_rd(mem_addr);
    end

    int          obs_done, obs_nwr;
    logic [31:0] obs_data;
    logic [31:0] obs_wa [8];
    logic [7:0]  obs_wd [8];
    logic [31:0] obs_ra [9];
    logic        obs_busy1, obs_other;

    task automatic run_txn(input bit lsu, input bit we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int st, input int sl);
        obs_done = -1; obs_nwr = 0; obs_busy1 = 0; obs_other = 0; obs_data = 0;
        if (lsu) begin
            lsu_req = 1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        for (int k = 0; k < 40 && obs_done < 0; k++) begin
            rdy_in = !(k >= st && k < st + sl);
            @(negedge clk_in);
            if (k >= 1 && k <= 8) obs_ra[k] = mem_addr;
            if (mem_wr && obs_nwr < 8) begin
                obs_wa[obs_nwr] = mem_addr; obs_wd[obs_nwr] = mem_dout; obs_nwr++;
            end
            if (k == 1) obs_busy1 = busy;
            if (lsu ? lsu_done : if_done) begin
                obs_done  = k;
                obs_data  = lsu ? lsu_rdata : if_data;
                obs_other = lsu ? if_done : lsu_done;
            end
            @(posedge clk_in); #1;
        end
        lsu_req = 0; if_req = 0; rdy_in = 1;
    endtask

    task automatic test_reset;
        rst_in = 1; rdy_in = 1; if_req = 0; if_flush = 0; lsu_req = 0; lsu_we = 0;
        lsu_size = 0; if_addr = 0; lsu_addr = 0; lsu_wdata = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks += 8;
        if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); end
        if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done: got %b expected 0", if_done); end
        if (lsu_done !== 1'b0) begin errors++; $display("FAIL reset_lsu_done: got %b expected 0", lsu_done); end
        if (if_data !== 32'd0) begin errors++; $display("FAIL reset_if_data: got %h expected 0", if_data); end
        if (lsu_rdata !== 32'd0) begin errors++; $display("FAIL reset_lsu_rdata: got %h expected 0", lsu_rdata); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk_in); #1;
        rst_in = 0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_word_load;
        logic [7:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            env_mem[32'h100 + 32'(i)] = b[i]; ref_mem[32'h100 + 32'(i)] = b[i];
        end
        run_txn(1, 0, 2'b10, 32'h100, 0, 0, 0);
        checks += 4;
        if (obs_done !== 6) begin errors++; $display("FAIL word_load_done: got %0d expected 6", obs_done); end
        if (obs_data !== 32'h44332211) begin errors++; $display("FAIL word_load_data: got %h expected 44332211", obs_data); end
        if (obs_busy1 !== 1'b1) begin errors++; $display("FAIL word_load_busy: got %b expected 1", obs_busy1); end
        if (obs_nwr !== 0) begin errors++; $display("FAIL word_load_wr: got %0d writes expected 0", obs_nwr); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (obs_ra[i] !== 32'hFF + 32'(i)) begin
                errors++; $display("FAIL word_load_addr%0d: got %h expected %h", i, obs_ra[i], 32'hFF + 32'(i));
            end
        end
    endtask

    task automatic test_half_store;
        run_txn(1, 1, 2'b01, 32'h1FFFF, 32'h0000BEEF, 0, 0);
        ref_mem[32'h1FFFF] = 8'hEF; ref_mem[32'h20000] = 8'hBE;
        checks += 4;
        if (obs_done !== 3) begin errors++; $display("FAIL half_store_done: got %0d expected 3", obs_done); end
        if (obs_nwr !== 2) begin errors++; $display("FAIL half_store_nwr: got %0d expected 2", obs_nwr); end
        if (obs_wa[0] !== 32'h1FFFF || obs_wd[0] !== 8'hEF)
            begin errors++; $display("FAIL half_store_b0: got %h/%h expected 0001ffff/ef", obs_wa[0], obs_wd[0]); end
        if (obs_wa[1] !== 32'h20000 || obs_wd[1] !== 8'hBE)
            begin errors++; $display("FAIL half_store_b1: got %h/%h expected 00020000/be", obs_wa[1], obs_wd[1]); end
    endtask

    task automatic test_priority;
        int ld, id;
        logic [31:0] ldat, idat;
        ld = -1; id = -1; ldat = 0; idat = 0;
        lsu_req = 1; lsu_we = 0; lsu_size = 2'b00; lsu_addr = 32'h2345;
        if_req = 1; if_addr = 32'h3001;
        for (int k = 0; k < 30 && id < 0; k++) begin
            @(negedge clk_in);
            if (lsu_done && ld < 0) begin ld = k; ldat = lsu_rdata; end
            if (if_done && id < 0) begin id = k; idat = if_data; end
            @(posedge clk_in); #1;
            if (ld >= 0) lsu_req = 0;
            if (id >= 0) if_req = 0;
        end
        lsu_req = 0; if_req = 0;
        checks += 4;
        if (ld !== 3) begin errors++; $display("FAIL prio_lsu_done: got %0d expected 3", ld); end
        if (id !== 10) begin errors++; $display("FAIL prio_if_done: got %0d expected 10", id); end
        if (ldat !== {24'd0, ref_rd(32'h2345)})
            begin errors++; $display("FAIL prio_lsu_data: got %h expected %h", ldat, {24'd0, ref_rd(32'h2345)}); end
        if (idat !== ref_word(32'h3001, 4))
            begin errors++; $display("FAIL prio_if_data: got %h expected %h", idat, ref_word(32'h3001, 4)); end
    endtask

    task automatic test_stall;
        int lens [2];
        lens[0] = 1; lens[1] = 3;
        for (int j = 0; j < 2; j++) begin
            run_txn(0, 0, 2'b10, 32'h0, 0, 3, lens[j]);
            checks += 3;
            if (obs_done !== 6 + lens[j] + 1)
                begin errors++; $display("FAIL stall%0d_done: got %0d expected %0d", lens[j], obs_done, 7 + lens[j]); end
            if (obs_data !== ref_word(32'h0, 4))
                begin errors++; $display("FAIL stall%0d_data: got %h expected %h", lens[j], obs_data, ref_word(32'h0, 4)); end
            if (obs_nwr !== 0)
                begin errors++; $display("FAIL stall%0d_wr: got %0d writes expected 0", lens[j], obs_nwr); end
        end
    endtask

    task automatic test_flush;
        int ld;
        logic saw_if, busy4;
        logic [31:0] ldat;
        ld = -1; saw_if = 0; busy4 = 1; ldat = 0;
        if_req = 1; if_addr = 32'h4000;
        for (int k = 0; k < 20 && ld < 0; k++) begin
            if (k == 1) begin lsu_req = 1; lsu_we = 0; lsu_size = 2'b00; lsu_addr = 32'h4100; end
            if (k == 3) if_flush = 1;
            if (k == 4) begin if_flush = 0; if_req = 0; end
            @(negedge clk_in);
            if (k == 4) busy4 = busy;
            if (if_done) saw_if = 1;
            if (lsu_done) begin ld = k; ldat = lsu_rdata; end
            @(posedge clk_in); #1;
        end
        lsu_req = 0; if_req = 0; if_flush = 0;
        checks += 4;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b expected 0", busy4); end
        if (saw_if !== 1'b0) begin errors++; $display("FAIL flush_no_done: got if_done=%b expected 0", saw_if); end
        if (ld !== 7) begin errors++; $display("FAIL flush_lsu_done: got %0d expected 7", ld); end
        if (ldat !== {24'd0, ref_rd(32'h4100)})
            begin errors++; $display("FAIL flush_lsu_data: got %h expected %h", ldat, {24'd0, ref_rd(32'h4100)}); end
    endtask

    task automatic test_reset_mid;
        logic saw_done, wr3, busy3;
        logic [31:0] a3;
        saw_done = 0; wr3 = 1; busy3 = 1; a3 = 32'hX;
        lsu_req = 1; lsu_we = 1; lsu_size = 2'b10; lsu_addr = 32'h8000_0000; lsu_wdata = 32'hCAFEF00D;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin rst_in = 1; lsu_req = 0; end
            if (k == 3) rst_in = 0;
            @(negedge clk_in);
            if (lsu_done) saw_done = 1;
            if (k == 3) begin wr3 = mem_wr; busy3 = busy; a3 = mem_addr; end
            @(posedge clk_in); #1;
        end
        checks += 4;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got lsu_done=%b expected 0", saw_done); end
        if (wr3 !== 1'b0) begin errors++; $display("FAIL rst_mid_wr: got %b expected 0", wr3); end
        if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy3); end
        if (a3 !== 32'd0) begin errors++; $display("FAIL rst_mid_addr: got %h expected 0", a3); end
    endtask

    task automatic test_random;
        bit lsu, we;
        logic [1:0] size;
        logic [31:0] addr, wdata;
        int n, st, sl, exp_done;
        logic ok;
        for (int t = 0; t < 30; t++) begin
            lsu   = $urandom_range(0, 3) != 0;
            we    = lsu ? 1'($urandom_range(0, 1)) : 1'b0;
            size  = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h1000 + 32'($urandom_range(0, 255));
            wdata = $urandom;
            n     = lsu ? nbytes(size) : 4;
            st = 0; sl = 0;
            if ($urandom_range(0, 1) == 1) begin
                sl = $urandom_range(1, 3);
                st = we ? $urandom_range(1, n) : $urandom_range(2, n + 1);
            end
            exp_done = we ? n + 1 + sl : n + 2 + (sl > 0 ? sl + 1 : 0);
            run_txn(lsu, we, size, addr, wdata, st, sl);
            checks += 3;
            if (obs_done !== exp_done)
                begin errors++; $display("FAIL rand%0d_done: got %0d expected %0d", t, obs_done, exp_done); end
            if (obs_other !== 1'b0)
                begin errors++; $display("FAIL rand%0d_other_done: got %b expected 0", t, obs_other); end
            if (obs_busy1 !== 1'b1)
                begin errors++; $display("FAIL rand%0d_busy: got %b expected 1", t, obs_busy1); end
            checks++;
            if (we) begin
                ok = obs_nwr == n;
                for (int i = 0; i < n && i < obs_nwr; i++)
                    if (obs_wa[i] !== addr + 32'(i) || obs_wd[i] !== wdata[8*i +: 8]) ok = 0;
                if (!ok) begin errors++; $display("FAIL rand%0d_store: got %0d writes first %h/%h expected %0d at %h", t, obs_nwr, obs_wa[0], obs_wd[0], n, addr); end
                for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
            end else if (obs_data !== ref_word(addr, n) || obs_nwr !== 0) begin
                errors++; $display("FAIL rand%0d_load: got %h expected %h (writes %0d)", t, obs_data, ref_word(addr, n), obs_nwr);
            end
            @(negedge clk_in);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_idle: got busy=%b expected 0", t, busy); end
            @(posedge clk_in); #1;
        end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_half_store;
        test_priority;
        test_stall;
        test_flush;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide memory port between instruction fetch (IF) and the load/store unit (LSU) of the RV32I core. It grants one requester at a time, splits each access into byte transfers at address+i, and assembles little-endian words. It honours the read-takes-two-cycles / write-takes-one memory protocol and the global `rdy_in` pause. It sits between the fetch/LSU stages and the `mem_*` pins of the cpu top.

## Interface
- No parameters.
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; one clock; reset is synchronous and active-high
- `rdy_in`  in  1  global ready; low = pause
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_done` or flush
- `if_addr`  in  32  fetch byte address, no alignment required
- `if_flush`  in  1  abort in-progress or pending fetch
- `if_done`  out  1  one-cycle pulse; `if_data` valid
- `if_data`  out  32  fetched word
- `lsu_req`  in  1  LSU request; held with operands stable until `lsu_done`
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_size`  in  2  00 byte, 01 half, 10 and 11 word (n = 1/2/4)
- `lsu_addr`  in  32  byte address, no alignment required
- `lsu_wdata`  in  32  store data, byte i = `[8i+7:8i]`
- `lsu_done`  out  1  one-cycle pulse; load data valid / store complete
- `lsu_rdata`  out  32  load data, zero-extended above n bytes
- `mem_din`  in  8  memory read byte
- `mem_dout`  out  8  memory write byte
- `mem_addr`  out  32  memory byte address
- `mem_wr`  out  1  1 = write
- `busy`  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: sample requests.
  - READ: issue and capture bytes.
  - WRITE: issue bytes.
  - DONE: raise done for one cycle, then return to IDLE.
- Grant (IDLE only): `lsu_req` beats `if_req`. IF is always a 4-byte read.
- No preemption. A request arriving mid-transfer waits until the FSM is back in IDLE.
- Memory protocol: `mem_din` in cycle c+1 holds the byte addressed by `mem_addr` in cycle c. Writes take effect in the cycle `mem_wr` = 1.
- READ is pipelined:
  - Address index i is issued in cycle i+1 after the grant cycle.
  - The byte arrives one cycle later and is stored into `data[8i+7:8i]`.
  - Counters: `issue_idx` and `recv_cnt`, 0..4.
- WRITE presents `mem_addr` = addr+i, `mem_dout` = wdata byte i, `mem_wr` = 1 for i = 0..n-1, one byte per cycle.
- Address arithmetic is 32-bit, addr+i mod 2^32.
- Output registers:
  - `mem_*` are registered.
  - Outside WRITE, `mem_wr` = 0; `mem_addr` and `mem_dout` hold their last value.
  - `if_data` / `lsu_rdata` update only in DONE and hold afterwards.
- `if_flush` with `rdy_in` high, while IF is granted (READ) or IF done is pending:
  - FSM goes to IDLE next cycle.
  - No `if_done` is issued.
  - Bytes in flight are discarded.
- `if_flush` has no effect on LSU transactions.
- Stall (`rdy_in` low):
  - `mem_wr` is forced 0 combinationally.
  - FSM, counters, done pulses and data registers all hold.
  - Exception, in READ only: at each stalled edge, `mem_addr` ← addr+`recv_cnt`, `issue_idx` ← `recv_cnt`+1, and the in-flight flag is cleared.
  - The first ready cycle after a READ stall captures nothing. Capture resumes the following cycle. No byte is lost or duplicated.
- Stall in WRITE: the presented byte is held and written once `rdy_in` returns.
- Reset:
  - FSM → IDLE; counters 0.
  - `mem_wr` = 0, `mem_addr` = 0, `mem_dout` = 0.
  - `if_done` = `lsu_done` = 0, `if_data` = `lsu_rdata` = 0, `busy` = 0.
  - Any in-progress transaction is abandoned with no done pulse.

## Timing
- Cycle 0 = IDLE cycle in which the request is sampled.
- Read of n bytes:
  - Addresses presented in cycles 1..n.
  - Captures at the ends of cycles 2..n+1.
  - Done high in cycle n+2.
  - IF word fetch: done in cycle 6.
- Write of n bytes: `mem_wr` high in cycles 1..n; done in cycle n+1.
- DONE lasts exactly one cycle; IDLE follows.
- Requesters must drop `req` in the cycle after done. The earliest next grant is the cycle after DONE.
- Each stall adds (stall length) cycles to the transaction. A stall in READ adds one further bubble cycle.
- `busy` = 1 from cycle 1 through DONE inclusive.

## Test plan
- Reset, then LSU word load at 0x100 holding bytes 11 22 33 44:
  - `mem_addr` 0x100..0x103 in cycles 1..4.
  - `lsu_done` in cycle 6, `lsu_rdata` = 0x44332211.
- LSU half store 0xBEEF at 0x1FFFF:
  - `mem_wr` cycles 1–2 at 0x1FFFF (EF) and 0x20000 (BE).
  - `lsu_done` in cycle 3.
  - `mem_wr` = 0 in cycle 3.
- `if_req` and `lsu_req` asserted in the same IDLE cycle:
  - LSU byte load completes first (done cycle 3).
  - IF is granted in IDLE after DONE; `if_done` 7 cycles later.
- IF fetch of 0x0 with `rdy_in` low for 1 and then 3 cycles mid-READ:
  - `if_data` equals memory contents.
  - Done delayed by 2 and 4 cycles respectively.
  - `mem_wr` stays 0 throughout.
- `if_flush` in cycle 3 of a fetch:
  - IDLE in cycle 4, no `if_done`.
  - A pending `lsu_req` is granted in that IDLE cycle.
- `rst_in` asserted in cycle 2 of a word store: no `lsu_done`, `mem_wr` = 0, `busy` = 0 after the reset edge.
